// File: rtl/alu_seq_add_if.sv
// Bundle between the byte-serial add/sub sequencer and its client plus external 8-bit adder.
// master: client drives start/sub/cin/op_a/op_b and adder result ad_s/ad_cv; slave: sequencer.
interface alu_seq_add_if #(
  parameter int NBYTE = 2
);
  localparam int W = NBYTE * 8;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  logic [7:0]   ad_a;
  logic [7:0]   ad_b;
  logic [7:0]   ad_c;
  logic [7:0]   ad_s;
  logic [7:0]   ad_cv;

  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         carry;
  logic         aux_c;
  logic         zero;

  modport master (
    output start, sub, cin, op_a, op_b,
    output ad_s, ad_cv,
    input  ad_a, ad_b, ad_c,
    input  busy, done, res, carry, aux_c, zero
  );

  modport slave (
    input  start, sub, cin, op_a, op_b,
    input  ad_s, ad_cv,
    output ad_a, ad_b, ad_c,
    output busy, done, res, carry, aux_c, zero
  );
endinterface

// File: rtl/alu_seq_add.sv
// Multi-byte add/sub sequencer sharing one external 8-bit adder, LSB byte first.
// Ports: clk, rst_n (sync, active-low), bus (alu_seq_add_if.slave). Option: ALU_SEQ_SUB_EN.
module alu_seq_add #(
  parameter int NBYTE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_add_if.slave   bus
);
  localparam int W  = NBYTE * 8;
  localparam int KW = (NBYTE > 1) ? $clog2(NBYTE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          cin_q;
  logic          crg;
  logic          ac_q;
  logic          carry_q;
  logic          zero_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_nxt;

  logic          run;
  logic          last;
  logic          accept;
  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic          cin0;
  logic          c_in;
  logic          carry_out;

  // Only bits 7 and 3 of the carry vector matter.
  logic          unused_cv;
  assign unused_cv = ^{bus.ad_cv[6:4], bus.ad_cv[2:0]};

  assign run    = (state == S_RUN);
  assign last   = (k == KW'(NBYTE - 1));
  assign accept = bus.start && (state != S_RUN);

  assign a_byte = a_q[k*8 +: 8];

`ifdef ALU_SEQ_SUB_EN
  logic sub_q;

  assign b_byte    = b_q[k*8 +: 8] ^ {8{sub_q}};
  assign cin0      = sub_q | cin_q;
  // Subtract reports borrow, the inverse of the final carry.
  assign carry_out = bus.ad_cv[7] ^ sub_q;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;

  assign b_byte    = b_q[k*8 +: 8];
  assign cin0      = cin_q;
  assign carry_out = bus.ad_cv[7];
`endif

  assign c_in = (k == '0) ? cin0 : crg;

  assign bus.ad_a = run ? a_byte : 8'h00;
  assign bus.ad_b = run ? b_byte : 8'h00;
  assign bus.ad_c = {7'b0, run & c_in};

  // Result with the current byte merged, so Z sees the final value.
  always_comb begin
    res_nxt           = res_q;
    res_nxt[k*8 +: 8] = bus.ad_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      crg     <= 1'b0;
      ac_q    <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      res_q   <= '0;
`ifdef ALU_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            cin_q <= bus.cin;
`ifdef ALU_SEQ_SUB_EN
            sub_q <= bus.sub;
`endif
            k     <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          res_q[k*8 +: 8] <= bus.ad_s;
          crg             <= bus.ad_cv[7];
          if (k == '0) begin
            ac_q <= bus.ad_cv[3];
          end
          if (last) begin
            carry_q <= carry_out;
            zero_q  <= (res_nxt == '0);
            state   <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = run;
  assign bus.done  = (state == S_DONE);
  assign bus.res   = res_q;
  assign bus.carry = carry_q;
  assign bus.aux_c = ac_q;
  assign bus.zero  = zero_q;
endmodule
